// File: rtl/lampfpu_sqrt_sched.sv
// Round-robin front end sharing one lampFPU sqrt/invSqrt unit among NUM_REQ requesters.
// Holds the unit's operands for the whole operation and returns a tagged, back-pressured result.
module lampfpu_sqrt_sched #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_LAT         = 64,
  parameter int LAMP_FLOAT_S_DW = 1,
  parameter int LAMP_FLOAT_E_DW = 8,
  parameter int LAMP_FLOAT_F_DW = 7,
  localparam int IDW            = $clog2(NUM_REQ),
  localparam int SW             = LAMP_FLOAT_S_DW,
  localparam int EW             = LAMP_FLOAT_E_DW,
  localparam int FW             = LAMP_FLOAT_F_DW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_inv_i,
  input  logic [NUM_REQ*SW-1:0]     req_s_i,
  input  logic [NUM_REQ*EW-1:0]     req_e_i,
  input  logic [NUM_REQ*(FW+1)-1:0] req_m_i,
  input  logic [NUM_REQ*4-1:0]      req_cls_i,
  output logic                      doSqrt_o,
  output logic                      invSqrt_o,
  output logic [SW-1:0]             signum_op_o,
  output logic [EW-1:0]             extExp_op_o,
  output logic [FW:0]               extMant_op_o,
  output logic                      isZero_op_o,
  output logic                      isInf_op_o,
  output logic                      isSNAN_op_o,
  output logic                      isQNAN_op_o,
  input  logic                      valid_i,
  input  logic [SW-1:0]             s_res_i,
  input  logic [EW-1:0]             e_res_i,
  input  logic [FW-1:0]             f_res_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [IDW-1:0]            resp_id_o,
  output logic [SW-1:0]             resp_s_o,
  output logic [EW-1:0]             resp_e_o,
  output logic [FW-1:0]             resp_f_o,
  output logic                      resp_err_o,
  output logic                      busy_o
);

  localparam int CW = $clog2(MAX_LAT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [IDW-1:0]   r_ptr;
  logic [CW-1:0]    r_cnt;

  logic [IDW-1:0]   r_id;
  logic             r_inv;
  logic [SW-1:0]    r_s;
  logic [EW-1:0]    r_e;
  logic [FW:0]      r_m;
  logic [3:0]       r_cls;

  logic [SW-1:0]    r_res_s;
  logic [EW-1:0]    r_res_e;
  logic [FW-1:0]    r_res_f;
  logic             r_res_err;

  logic             w_found;
  logic [IDW-1:0]   w_winner;
  logic [IDW-1:0]   w_idx;
  logic             w_accept;
  logic             w_timeout;
  logic             w_in_busy;
  logic             w_in_resp;

  // Round-robin search starting just after the last winner.
  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid_i[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_in_busy = (r_state == ST_BUSY);
  assign w_in_resp = (r_state == ST_RESP);
  assign w_accept  = (r_state == ST_IDLE) && w_found;
  assign w_timeout = (r_cnt == CW'(MAX_LAT - 1));

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (w_found)                w_next_state = ST_BUSY;
      ST_BUSY: if (valid_i || w_timeout)   w_next_state = ST_RESP;
      ST_RESP: if (resp_ready_i)           w_next_state = ST_IDLE;
      default:                             w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= IDW'(NUM_REQ - 1);
      r_cnt     <= '0;
      r_id      <= '0;
      r_inv     <= 1'b0;
      r_s       <= '0;
      r_e       <= '0;
      r_m       <= '0;
      r_cls     <= '0;
      r_res_s   <= '0;
      r_res_e   <= '0;
      r_res_f   <= '0;
      r_res_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ptr <= w_winner;
            r_id  <= w_winner;
            r_cnt <= '0;
            r_inv <= req_inv_i[w_winner];
            r_s   <= req_s_i[w_winner*SW +: SW];
            r_e   <= req_e_i[w_winner*EW +: EW];
            r_m   <= req_m_i[w_winner*(FW+1) +: (FW+1)];
            r_cls <= req_cls_i[w_winner*4 +: 4];
          end
        end
        ST_BUSY: begin
          // A result arriving in the timeout cycle still counts as a success.
          if (valid_i) begin
            r_res_s   <= s_res_i;
            r_res_e   <= e_res_i;
            r_res_f   <= f_res_i;
            r_res_err <= 1'b0;
          end else if (w_timeout) begin
            r_res_s   <= '0;
            r_res_e   <= '0;
            r_res_f   <= '0;
            r_res_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Grant is suppressed while reset is held so every output reads 0 during reset.
  assign req_ready_o  = (w_accept && !rst) ? (NUM_REQ'(1) << w_winner) : '0;

  assign doSqrt_o     = w_in_busy;
  assign invSqrt_o    = w_in_busy & r_inv;
  assign signum_op_o  = w_in_busy ? r_s : '0;
  assign extExp_op_o  = w_in_busy ? r_e : '0;
  assign extMant_op_o = w_in_busy ? r_m : '0;
  assign isZero_op_o  = w_in_busy & r_cls[3];
  assign isInf_op_o   = w_in_busy & r_cls[2];
  assign isSNAN_op_o  = w_in_busy & r_cls[1];
  assign isQNAN_op_o  = w_in_busy & r_cls[0];

  assign resp_valid_o = w_in_resp;
  assign resp_id_o    = w_in_resp ? r_id    : '0;
  assign resp_s_o     = w_in_resp ? r_res_s : '0;
  assign resp_e_o     = w_in_resp ? r_res_e : '0;
  assign resp_f_o     = w_in_resp ? r_res_f : '0;
  assign resp_err_o   = w_in_resp & r_res_err;

  assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lampfpu_sqrt_sched.sv
// Bench for lampfpu_sqrt_sched: a toy sqrt unit with programmable latency, a transaction-level
// scheduler model compared every cycle, and directed scenarios with literal expectations.
module tb_lampfpu_sqrt_sched;

  localparam int N  = 4;
  localparam int ML = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [3:0]   req_inv;
  logic [3:0]   req_s;
  logic [31:0]  req_e;
  logic [31:0]  req_m;
  logic [15:0]  req_cls;
  logic         do_sqrt, inv_sqrt;
  logic         op_s;
  logic [7:0]   op_e;
  logic [7:0]   op_m;
  logic         op_zero, op_inf, op_snan, op_qnan;
  logic         valid_u;
  logic         res_s;
  logic [7:0]   res_e;
  logic [6:0]   res_f;
  logic         resp_valid;
  logic         resp_ready = 1'b1;
  logic [1:0]   resp_id;
  logic         resp_s;
  logic [7:0]   resp_e;
  logic [6:0]   resp_f;
  logic         resp_err;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  lampfpu_sqrt_sched #(.NUM_REQ(N), .MAX_LAT(ML)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_inv_i(req_inv),
    .req_s_i(req_s), .req_e_i(req_e), .req_m_i(req_m), .req_cls_i(req_cls),
    .doSqrt_o(do_sqrt), .invSqrt_o(inv_sqrt),
    .signum_op_o(op_s), .extExp_op_o(op_e), .extMant_op_o(op_m),
    .isZero_op_o(op_zero), .isInf_op_o(op_inf), .isSNAN_op_o(op_snan), .isQNAN_op_o(op_qnan),
    .valid_i(valid_u), .s_res_i(res_s), .e_res_i(res_e), .f_res_i(res_f),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_id_o(resp_id),
    .resp_s_o(resp_s), .resp_e_o(resp_e), .resp_f_o(resp_f), .resp_err_o(resp_err),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Toy unit: answers unit_lat cycles after doSqrt rises (0 = never); force_valid injects strays.
  int   unit_lat = 4;
  logic force_valid = 1'b0;
  int   u_cnt = 0;
  always @(posedge clk) u_cnt <= do_sqrt ? u_cnt + 1 : 0;
  assign valid_u = force_valid | (unit_lat != 0 && do_sqrt && u_cnt == unit_lat - 1);
  assign res_s   = op_s ^ inv_sqrt;
  assign res_e   = op_e ^ {7'b0, inv_sqrt};
  assign res_f   = ~op_m[6:0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Transaction model: one op in flight; doSqrt for m_dur cycles, then a response until accepted.
  bit         m_active = 0;
  int         m_ptr = N - 1;
  int         m_age = 0;
  int         m_dur = 0;
  logic [1:0] m_id;
  logic       m_inv, m_s, m_err;
  logic [7:0] m_e, m_m, x_e;
  logic [3:0] m_cls;
  logic       x_s;
  logic [6:0] x_f;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0;
      m_ptr    = N - 1;
      m_age    = 0;
    end else if (!m_active) begin
      int w;
      w = pick(req_valid, m_ptr);
      if (w >= 0) begin
        m_active = 1;
        m_age    = 1;
        m_ptr    = w;
        m_id     = w[1:0];
        m_inv    = req_inv[w];
        m_s      = req_s[w];
        m_e      = req_e[w*8 +: 8];
        m_m      = req_m[w*8 +: 8];
        m_cls    = req_cls[w*4 +: 4];
        if (unit_lat != 0 && unit_lat <= ML) begin
          m_dur = unit_lat;
          m_err = 0;
          x_s   = m_s ^ m_inv;
          x_e   = m_e ^ {7'b0, m_inv};
          x_f   = ~m_m[6:0];
        end else begin
          m_dur = ML;
          m_err = 1;
          x_s   = 0;
          x_e   = 0;
          x_f   = 0;
        end
      end
    end else if (m_age > m_dur) begin
      if (resp_ready) m_active = 0;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_rdy;
    bit d_exp, r_exp;
    int w;
    exp_rdy = '0;
    if (!rst && !m_active) begin
      w = pick(req_valid, m_ptr);
      if (w >= 0) exp_rdy = 4'b0001 << w;
    end
    d_exp = m_active && m_age <= m_dur;
    r_exp = m_active && m_age > m_dur;
    check("req_ready", req_ready, exp_rdy);
    check("busy", busy, m_active);
    check("doSqrt", do_sqrt, d_exp);
    check("invSqrt", inv_sqrt, d_exp & m_inv);
    check("operands", {op_s, op_e, op_m, op_zero, op_inf, op_snan, op_qnan},
          d_exp ? {m_s, m_e, m_m, m_cls} : 21'h0);
    check("resp_valid", resp_valid, r_exp);
    check("resp_fields", {resp_id, resp_s, resp_e, resp_f, resp_err},
          r_exp ? {m_id, x_s, x_e, x_f, m_err} : 19'h0);
  end

  int obs[$];
  always @(posedge clk)
    if (!rst) for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) obs.push_back(i);

  task automatic wait_grant(input int id, input string nm);
    logic [3:0] seen;
    seen = '0;
    for (int c = 0; c < 300 && seen == 0; c++) begin
      @(negedge clk);
      seen = req_ready;
    end
    check(nm, seen, 4'b0001 << id);
    @(posedge clk); #2;
  endtask

  task automatic wait_resp(output int dcnt);
    bit got;
    got  = 0;
    dcnt = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (do_sqrt) dcnt++;
      if (resp_valid) got = 1;
    end
    check("resp_arrives", got, 1'b1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int c = 0; c < 300 && !idle; c++) begin
      @(negedge clk);
      idle = !busy;
    end
    check("returns_idle", idle, 1'b1);
    @(posedge clk); #2;
  endtask

  int d;
  int base;
  logic [18:0] snap;

  initial begin
    req_inv = 4'b0101;
    req_s   = 4'b1010;
    req_e   = {8'h01, 8'h40, 8'h7F, 8'b10000101};
    req_m   = {8'hFF, 8'h81, 8'hC0, 8'b11111000};
    req_cls = {4'b1000, 4'b0100, 4'b0000, 4'b0000};

    #1 rst = 1'b1;
    #2;
    check("reset_busy", busy, 1'b0);
    check("reset_outs", {do_sqrt, resp_valid, req_ready, resp_err}, 7'h0);
    @(posedge clk); #2 rst = 1'b0;

    // 1: single op from req0
    unit_lat  = 4;
    req_valid = 4'b0001;
    wait_grant(0, "t1_grant_req0");
    req_valid = '0;
    wait_resp(d);
    check("t1_dosqrt_cycles", d, 4);
    check("t1_resp", {resp_id, resp_err, resp_s, resp_e, resp_f},
          {2'd0, 1'b0, 1'b1, 8'h84, 7'h07});
    wait_idle();

    // 2: all four contending from a fresh pointer
    rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    unit_lat  = 3;
    base      = obs.size();
    req_valid = 4'hF;
    for (int c = 0; c < 300 && obs.size() < base + 6; c++) begin
      @(posedge clk); #2;
    end
    req_valid = '0;
    wait_idle();
    for (int k = 0; k < 6; k++)
      check("t2_grant_order", (obs.size() > base + k) ? obs[base + k] : -1, k % 4);

    // 3: back-pressured response
    unit_lat   = 2;
    resp_ready = 1'b0;
    req_valid  = 4'b0100;
    wait_grant(2, "t3_grant_req2");
    req_valid = '0;
    wait_resp(d);
    snap = {resp_id, resp_s, resp_e, resp_f, resp_err};
    check("t3_resp", snap, {2'd2, 1'b1, 8'h41, 7'h7E, 1'b0});
    @(posedge clk); #2 req_valid = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t3_hold_state", {busy, do_sqrt, req_ready}, {1'b1, 1'b0, 4'b0000});
      check("t3_hold_fields", {resp_id, resp_s, resp_e, resp_f, resp_err}, snap);
    end
    @(posedge clk); #2 resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t3_next_grant", {busy, req_ready}, {1'b0, 4'b0010});
    @(posedge clk); #2 req_valid = '0;
    wait_idle();

    // 4: hung unit triggers the watchdog; strays afterwards are ignored
    unit_lat   = 0;
    resp_ready = 1'b0;
    req_valid  = 4'b1000;
    wait_grant(3, "t4_grant_req3");
    req_valid = '0;
    wait_resp(d);
    check("t4_dosqrt_cycles", d, 64);
    check("t4_resp", {resp_id, resp_err, resp_s, resp_e, resp_f}, {2'd3, 1'b1, 16'h0});
    force_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2 force_valid = 1'b0;
    @(negedge clk);
    check("t4_stray_resp", {resp_valid, resp_err, resp_s, resp_e, resp_f}, {2'b11, 16'h0});
    resp_ready = 1'b1;
    wait_idle();
    force_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2 force_valid = 1'b0;
    @(negedge clk);
    check("t4_stray_idle", {busy, resp_valid}, 2'b00);

    // 5: result arrives in the final watchdog cycle
    unit_lat  = 64;
    req_valid = 4'b0010;
    wait_grant(1, "t5_grant_req1");
    req_valid = '0;
    wait_resp(d);
    check("t5_dosqrt_cycles", d, 64);
    check("t5_resp", {resp_id, resp_err, resp_s, resp_e, resp_f},
          {2'd1, 1'b0, 1'b1, 8'h7F, 7'h3F});
    wait_idle();

    // 6: reset in the middle of an operation
    unit_lat  = 0;
    req_valid = 4'b0001;
    wait_grant(0, "t6_grant_req0");
    req_valid = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    req_valid = 4'b0011;
    #1;
    check("t6_async_clear", {busy, do_sqrt, resp_valid, req_ready, op_e, op_m},
          {3'b000, 4'b0000, 16'h0});
    @(posedge clk); #2;
    unit_lat = 3;
    rst      = 1'b0;
    wait_grant(0, "t6_first_after_reset");
    req_valid = 4'b0010;
    wait_grant(1, "t6_then_req1");
    req_valid = '0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
